// File: rtl/div_pkg.sv
// Shared types and constant helpers for the sequential restoring divider family.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the full iteration count N.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Saturation patterns, valid for widths up to 63 bits.
  function automatic logic [63:0] ones_c(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] smax_c(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin_c(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step: partial remainder plus next
// dividend bit in, reduced partial remainder plus quotient bit out.
module div_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // The incoming remainder is always below the divisor, so the shifted trial
  // value fits WIDTH+1 bits and the kept remainder fits WIDTH bits.
  always_comb begin
    trial = {rem_i, bit_i};
    diff  = trial - {1'b0, dvs_i};
    q_o   = (trial >= {1'b0, dvs_i});
    rem_o = WIDTH'(q_o ? diff : trial);
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider with fixed-point quotient, remainder,
// divide-by-zero and saturating overflow. Define DIV_SIGNED_EN for signed mode (port sgn).
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int FRAC_BITS = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef DIV_SIGNED_EN
  input  logic             sgn,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             valid,
  output logic             ov,
  output logic             dvz
);

  localparam int N     = WIDTH + FRAC_BITS;
  localparam int CNT_W = cnt_w(N);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(ones_c(WIDTH));
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(smax_c(WIDTH));
  localparam logic [WIDTH-1:0] QMIN = WIDTH'(smin_c(WIDTH));

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [N-1:0]       quo_q, quo_d;
  logic [N-1:0]       dvd_q, dvd_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               neg_q, neg_d;
  logic               aneg_q, aneg_d;
  logic               sgn_q, sgn_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               ov_q, ov_d;
  logic               dvz_q, dvz_d;

  logic               sgn_in;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_rem;
  logic               step_bit;
  logic [N-1:0]       quo_nx;
  logic [WIDTH:0]     fix;

`ifdef DIV_SIGNED_EN
  assign sgn_in = sgn;
`else
  assign sgn_in = 1'b0;
`endif

  // The engine always divides magnitudes; signs are restored at completion.
  assign a_neg = sgn_in & A[WIDTH-1];
  assign b_neg = sgn_in & B[WIDTH-1];
  assign a_mag = a_neg ? -A : A;
  assign b_mag = b_neg ? -B : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .bit_i (dvd_q[N-1]),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .q_o   (step_bit)
  );

  // Returns {ov, Q}: range check of the N-bit magnitude quotient and sign fix-up.
  function automatic logic [WIDTH:0] sat_quo(input logic [N-1:0] mag,
                                              input logic neg,
                                              input logic smode);
    logic [WIDTH:0]   res;
    logic [N-1:0]     lim;
    logic [WIDTH-1:0] qv;
    qv  = mag[WIDTH-1:0];
    lim = neg ? N'(QMIN) : N'(QMAX);
    if (!smode) begin
      if ((mag >> WIDTH) != '0) res = {1'b1, ONES};
      else                      res = {1'b0, qv};
    end else if (mag > lim) begin
      res = {1'b1, neg ? QMIN : QMAX};
    end else begin
      res = {1'b0, neg ? -qv : qv};
    end
    return res;
  endfunction

  function automatic logic [WIDTH-1:0] fix_rem(input logic [WIDTH-1:0] mag,
                                                input logic neg);
    return neg ? -mag : mag;
  endfunction

  function automatic logic [WIDTH-1:0] dvz_quo(input logic neg, input logic smode);
    logic [WIDTH-1:0] res;
    if (!smode)   res = ONES;
    else if (neg) res = QMIN;
    else          res = QMAX;
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    aneg_d  = aneg_q;
    sgn_d   = sgn_q;
    q_d     = q_q;
    r_d     = r_q;
    ov_d    = ov_q;
    dvz_d   = dvz_q;
    quo_nx  = N'({quo_q, step_bit});
    fix     = '0;

    case (state_q)
      RUN: begin
        rem_d = step_rem;
        quo_d = quo_nx;
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          fix     = sat_quo(quo_nx, neg_q, sgn_q);
          ov_d    = fix[WIDTH];
          q_d     = fix[WIDTH-1:0];
          r_d     = fix_rem(step_rem, aneg_q);
          dvz_d   = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request on the same edge.
        if (start) begin
          sgn_d  = sgn_in;
          neg_d  = a_neg ^ b_neg;
          aneg_d = a_neg;
          dvs_d  = b_mag;
          if (B == '0) begin
            state_d = DONE;
            dvz_d   = 1'b1;
            ov_d    = 1'b1;
            q_d     = dvz_quo(a_neg, sgn_in);
            r_d     = A;
          end else begin
            state_d = RUN;
            cnt_d   = CNT_W'(N);
            rem_d   = '0;
            quo_d   = '0;
            dvd_d   = N'(a_mag) << FRAC_BITS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      ov_q    <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      ov_q    <= ov_d;
      dvz_q   <= dvz_d;
    end
  end

  // Iteration datapath is only read after a start has loaded it.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    neg_q  <= neg_d;
    aneg_q <= aneg_d;
    sgn_q  <= sgn_d;
  end

  assign Q     = q_q;
  assign R     = r_q;
  assign ov    = ov_q;
  assign dvz   = dvz_q;
  assign busy  = (state_q == RUN);
  assign valid = (state_q == DONE);

endmodule

// File: tb/tb_div_seq_param.sv
// Randomised bench for div_seq_param: two instances (FRAC_BITS 0 and 4) checked
// every cycle against an arithmetic reference model, plus literal spot checks.
module tb_div_seq_param;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       sgn   = 1'b0;
  logic [9:0] A     = '0;
  logic [9:0] B     = '0;

  logic [9:0] q0, r0, q1, r1;
  logic       busy0, valid0, ov0, dvz0;
  logic       busy1, valid1, ov1, dvz1;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  div_seq_param #(.WIDTH(10), .FRAC_BITS(0)) dut0 (
    .clk(clk), .rst(rst), .start(start),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .A(A), .B(B), .Q(q0), .R(r0),
    .busy(busy0), .valid(valid0), .ov(ov0), .dvz(dvz0)
  );

  div_seq_param #(.WIDTH(10), .FRAC_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .start(start),
`ifdef DIV_SIGNED_EN
    .sgn(sgn),
`endif
    .A(A), .B(B), .Q(q1), .R(r1),
    .busy(busy1), .valid(valid1), .ov(ov1), .dvz(dvz1)
  );

  // Expected {ov, dvz, Q, R} from plain integer arithmetic.
  function automatic logic [21:0] model_res(input int f, input logic [9:0] a,
                                            input logic [9:0] b, input logic sg);
    longint num, qq, rr, sa, sb, ma, mb, qs, rs;
    logic [9:0] q, r;
    logic o;
    if (b == 10'd0) begin
      if (sg) q = a[9] ? 10'h200 : 10'h1FF;
      else    q = 10'h3FF;
      return {1'b1, 1'b1, q, a};
    end
    if (!sg) begin
      num = longint'(a) << f;
      qq  = num / longint'(b);
      rr  = num % longint'(b);
      o   = (qq > 1023);
      q   = o ? 10'h3FF : qq[9:0];
      r   = rr[9:0];
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ma = (sa < 0 ? -sa : sa) << f;
      mb = (sb < 0 ? -sb : sb);
      qs = ((sa < 0) != (sb < 0)) ? -(ma / mb) : (ma / mb);
      rs = (sa < 0) ? -(ma % mb) : (ma % mb);
      o  = 1'b0;
      if (qs > 511) begin
        o = 1'b1; q = 10'h1FF;
      end else if (qs < -512) begin
        o = 1'b1; q = 10'h200;
      end else begin
        q = qs[9:0];
      end
      r = rs[9:0];
    end
    return {o, 1'b0, q, r};
  endfunction

  logic        m_busy  [2];
  logic        m_valid [2];
  int          m_left  [2];
  logic [21:0] m_out   [2];
  logic [21:0] m_pend  [2];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_valid[i] <= 1'b0;
        m_left[i]  <= 0;
        m_out[i]   <= '0;
        m_pend[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (start && !m_busy[i]) begin
          m_valid[i] <= (B == 10'd0);
          if (B == 10'd0) begin
            m_out[i] <= model_res(4 * i, A, B, sgn);
          end else begin
            m_busy[i] <= 1'b1;
            m_left[i] <= 10 + 4 * i;
            m_pend[i] <= model_res(4 * i, A, B, sgn);
          end
        end else if (m_busy[i]) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_busy[i]  <= 1'b0;
            m_valid[i] <= 1'b1;
            m_out[i]   <= m_pend[i];
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Field order {busy, valid, ov, dvz, Q, R}.
  always @(negedge clk) begin
    check("dut0_outputs", {busy0, valid0, ov0, dvz0, q0, r0}, {m_busy[0], m_valid[0], m_out[0]});
    check("dut1_outputs", {busy1, valid1, ov1, dvz1, q1, r1}, {m_busy[1], m_valid[1], m_out[1]});
  end

  task automatic wait_idle();
    for (int k = 0; k < 40; k++) begin
      if (!m_busy[0] && !m_busy[1]) break;
      @(negedge clk);
    end
    check("idle_wait", {22'd0, m_busy[0], m_busy[1]}, 24'd0);
  endtask

  task automatic op(input logic [9:0] a, input logic [9:0] b, input logic s);
    @(negedge clk);
    A = a; B = b; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dut0", {busy0, valid0, ov0, dvz0, q0, r0}, 24'd0);
    rst = 1'b1;

    op(10'd32, 10'd16, 1'b0);
    check("u_32_16_q", {14'd0, q0}, 24'd2);
    check("u_32_16_r", {12'd0, ov0, dvz0, r0}, 24'd0);

    op(10'd32, 10'd0, 1'b0);
    check("dvz_q", {12'd0, ov0, dvz0, q0}, {14'd0, 10'd1023} | 24'h000C00);
    check("dvz_r", {14'd0, r0}, 24'd32);

    op(10'd3, 10'd2, 1'b0);
    check("frac_3_2", {12'd0, ov1, dvz1, q1}, 24'd24);
    check("frac_3_2_r", {14'd0, r1}, 24'd0);

    op(10'd1000, 10'd1, 1'b0);
    check("frac_ov", {13'd0, ov1, q1}, 24'h7FF);

    // start held through RUN with changing operands must be ignored
    @(negedge clk);
    A = 10'd100; B = 10'd7; start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      A = 10'($urandom); B = 10'($urandom) | 10'd1;
    end
    start = 1'b0;
    wait_idle();
    check("held_start_q", {14'd0, q0}, 24'd14);
    check("held_start_r", {14'd0, r0}, 24'd2);

    op(10'd50, 10'd5, 1'b0);
    check("restart_q", {14'd0, q0}, 24'd10);

    // asynchronous reset in the middle of an operation
    @(negedge clk);
    A = 10'd200; B = 10'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrun_rst0", {busy0, valid0, ov0, dvz0, q0, r0}, 24'd0);
    check("midrun_rst1", {busy1, valid1, ov1, dvz1, q1, r1}, 24'd0);
    @(negedge clk);
    rst = 1'b1;
    op(10'd100, 10'd7, 1'b0);
    check("post_rst_q", {14'd0, q0}, 24'd14);
    check("post_rst_r", {14'd0, r0}, 24'd2);

    op(10'd1023, 10'd1, 1'b0);
    op(10'd0, 10'd5, 1'b0);
    op(10'd1023, 10'd1023, 1'b0);

`ifdef DIV_SIGNED_EN
    op(10'h3F9, 10'd2, 1'b1);
    check("s_m7_2_q", {14'd0, q0}, 24'h3FD);
    check("s_m7_2_r", {14'd0, r0}, 24'h3FF);
    op(10'h200, 10'h3FF, 1'b1);
    check("s_min_m1", {13'd0, ov0, q0}, 24'h5FF);
    op(10'h200, 10'd0, 1'b1);
    op(10'd5, 10'h3FF, 1'b1);
`endif

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      A = 10'($urandom);
      case ($urandom_range(0, 7))
        0:       B = 10'd0;
        1:       B = 10'd1;
        2:       B = 10'($urandom_range(1, 15));
        default: B = 10'($urandom);
      endcase
`ifdef DIV_SIGNED_EN
      sgn = 1'($urandom);
`else
      sgn = 1'b0;
`endif
    end
    start = 1'b0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
